// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: picks the oldest mispredicted branch writeback,
// holds it as a pending frontend redirect and filters younger FTQ updates.
package branch_redirect_pkg;
  localparam int unsigned XDEF      = 64;
  localparam int unsigned ROB_W_PKG = 6;
  localparam int unsigned FTQ_W     = 4;

  typedef logic [FTQ_W-1:0] ftqIdx_t;

  typedef enum logic [1:0] {
    isDirect,
    isCond,
    isIndirect,
    isRet
  } branch_type_t;

  typedef struct packed {
    branch_type_t          branch_type;
    logic [ROB_W_PKG-1:0]  rob_idx;
    ftqIdx_t               ftq_idx;
    logic                  has_mispred;
    logic                  branch_taken;
    logic [3:0]            fallthruOffset;
    logic [XDEF-1:0]       target_pc;
    logic [XDEF-1:0]       branch_npc;
  } branchwbInfo_t;
endpackage

module branch_redirect_ctrl
  import branch_redirect_pkg::*;
#(
  parameter int unsigned NUM_BRU = 2,
  parameter int unsigned ROB_W   = ROB_W_PKG,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic          [NUM_BRU-1:0]  i_branchwb_vld,
  input  branchwbInfo_t [NUM_BRU-1:0]  i_branchwbInfo,
  input  logic                         i_flush,
  output logic                         o_redirect_vld,
  input  logic                         i_redirect_rdy,
  output logic          [XDEF-1:0]     o_redirect_pc,
  output ftqIdx_t                      o_redirect_ftqIdx,
  output logic          [ROB_W-1:0]    o_redirect_robIdx,
  output logic          [NUM_BRU-1:0]  o_ftqupd_vld,
  output branchwbInfo_t [NUM_BRU-1:0]  o_ftqupdInfo,
  output logic          [CNT_W-1:0]    o_mispred_cnt
);

  // Wrap flag in the MSB: differing flags mean the larger index was allocated earlier.
  function automatic logic older(input logic [ROB_W-1:0] a, input logic [ROB_W-1:0] b);
    if (a[ROB_W-1] != b[ROB_W-1]) return a[ROB_W-2:0] > b[ROB_W-2:0];
    else                          return a[ROB_W-2:0] < b[ROB_W-2:0];
  endfunction

  logic               bnd_vld;
  logic [ROB_W-1:0]   bnd_rob;

  logic               cand_found;
  logic               cand_live;
  logic [ROB_W-1:0]   cand_rob;
  logic [XDEF-1:0]    cand_npc;
  ftqIdx_t            cand_ftq;
  logic [NUM_BRU-1:0] killed;

  always_comb begin
    cand_found = 1'b0;
    cand_rob   = '0;
    cand_npc   = '0;
    cand_ftq   = '0;
    for (int unsigned i = 0; i < NUM_BRU; i++) begin
      if (i_branchwb_vld[i] && i_branchwbInfo[i].has_mispred &&
          (!cand_found || older(i_branchwbInfo[i].rob_idx, cand_rob))) begin
        cand_found = 1'b1;
        cand_rob   = i_branchwbInfo[i].rob_idx;
        cand_npc   = i_branchwbInfo[i].branch_npc;
        cand_ftq   = i_branchwbInfo[i].ftq_idx;
      end
    end
    cand_live = cand_found && !(bnd_vld && !older(cand_rob, bnd_rob));
    killed = '0;
    for (int unsigned i = 0; i < NUM_BRU; i++) begin
      killed[i] = (bnd_vld && !older(i_branchwbInfo[i].rob_idx, bnd_rob)) ||
                  (cand_live && older(cand_rob, i_branchwbInfo[i].rob_idx));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_redirect_vld <= 1'b0;
      bnd_vld        <= 1'b0;
      o_ftqupd_vld   <= '0;
      o_mispred_cnt  <= '0;
    end else begin
      o_ftqupd_vld <= i_flush ? '0 : (i_branchwb_vld & ~killed);
      // An accepted redirect counts even when a new candidate overwrites it this cycle.
      if (!i_flush && o_redirect_vld && i_redirect_rdy)
        o_mispred_cnt <= o_mispred_cnt + CNT_W'(1);
      if (i_flush) begin
        o_redirect_vld <= 1'b0;
        bnd_vld        <= 1'b0;
      end else if (cand_live) begin
        o_redirect_vld <= 1'b1;
        bnd_vld        <= 1'b1;
      end else if (o_redirect_vld && i_redirect_rdy) begin
        o_redirect_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    o_ftqupdInfo <= i_branchwbInfo;
    if (!rst && !i_flush && cand_live) begin
      o_redirect_pc     <= cand_npc;
      o_redirect_ftqIdx <= cand_ftq;
      o_redirect_robIdx <= cand_rob;
      bnd_rob           <= cand_rob;
    end
  end

  for (genvar i = 0; i < NUM_BRU; i++) begin : g_chk
    a_no_direct_mispred: assert property (@(posedge clk) disable iff (rst)
      !(i_branchwb_vld[i] && i_branchwbInfo[i].has_mispred &&
        i_branchwbInfo[i].branch_type == isDirect));
    for (genvar j = i + 1; j < NUM_BRU; j++) begin : g_pair
      a_unique_rob: assert property (@(posedge clk) disable iff (rst)
        !(i_branchwb_vld[i] && i_branchwbInfo[i].has_mispred &&
          i_branchwb_vld[j] && i_branchwbInfo[j].has_mispred &&
          i_branchwbInfo[i].rob_idx == i_branchwbInfo[j].rob_idx));
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed self-checking bench for branch_redirect_ctrl.
module tb_branch_redirect_ctrl;
  import branch_redirect_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic          [1:0]    i_branchwb_vld;
  branchwbInfo_t [1:0]    i_branchwbInfo;
  logic                   i_flush;
  logic                   o_redirect_vld;
  logic                   i_redirect_rdy;
  logic          [63:0]   o_redirect_pc;
  ftqIdx_t                o_redirect_ftqIdx;
  logic          [5:0]    o_redirect_robIdx;
  logic          [1:0]    o_ftqupd_vld;
  branchwbInfo_t [1:0]    o_ftqupdInfo;
  logic          [31:0]   o_mispred_cnt;

  int checks = 0;
  int errors = 0;

  branch_redirect_ctrl #(.NUM_BRU(2), .ROB_W(6), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_branchwb_vld(i_branchwb_vld), .i_branchwbInfo(i_branchwbInfo),
    .i_flush(i_flush),
    .o_redirect_vld(o_redirect_vld), .i_redirect_rdy(i_redirect_rdy),
    .o_redirect_pc(o_redirect_pc), .o_redirect_ftqIdx(o_redirect_ftqIdx),
    .o_redirect_robIdx(o_redirect_robIdx),
    .o_ftqupd_vld(o_ftqupd_vld), .o_ftqupdInfo(o_ftqupdInfo),
    .o_mispred_cnt(o_mispred_cnt)
  );

  always #5 clk = ~clk;

  function automatic branchwbInfo_t mk(input logic [5:0] rob, input logic [63:0] npc, input logic mp);
    branchwbInfo_t r;
    r = '0;
    r.branch_type = mp ? isCond : isDirect;
    r.rob_idx     = rob;
    r.ftq_idx     = rob[3:0];
    r.has_mispred = mp;
    r.target_pc   = npc;
    r.branch_npc  = npc;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_branchwb_vld = '0;
    i_branchwbInfo = '0;
    i_flush        = 1'b0;
    i_redirect_rdy = 1'b0;
  endtask

  task automatic do_flush();
    idle();
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++; if (o_redirect_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %0b exp 0", o_redirect_vld); end
    checks++; if (o_ftqupd_vld !== 2'b00) begin errors++; $display("FAIL reset_ftqupd got %b exp 00", o_ftqupd_vld); end
    checks++; if (o_mispred_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", o_mispred_cnt); end
  endtask

  task automatic test_single();
    idle();
    i_branchwb_vld    = 2'b01;
    i_branchwbInfo[0] = mk(6'h05, 64'h8000_1000, 1'b1);
    step();
    checks++; if (o_redirect_vld !== 1'b1) begin errors++; $display("FAIL single_vld got %0b exp 1", o_redirect_vld); end
    checks++; if (o_redirect_pc !== 64'h8000_1000) begin errors++; $display("FAIL single_pc got %h exp 80001000", o_redirect_pc); end
    checks++; if (o_redirect_ftqIdx !== 4'h5) begin errors++; $display("FAIL single_ftq got %h exp 5", o_redirect_ftqIdx); end
    checks++; if (o_ftqupd_vld !== 2'b01) begin errors++; $display("FAIL single_ftqupd got %b exp 01", o_ftqupd_vld); end
    idle();
    i_redirect_rdy = 1'b1;
    step();
    checks++; if (o_redirect_vld !== 1'b0) begin errors++; $display("FAIL single_vld_after got %0b exp 0", o_redirect_vld); end
    checks++; if (o_mispred_cnt !== 32'd1) begin errors++; $display("FAIL single_cnt got %0d exp 1", o_mispred_cnt); end
    do_flush();
  endtask

  task automatic test_oldest();
    idle();
    i_branchwb_vld    = 2'b11;
    i_branchwbInfo[0] = mk(6'h09, 64'h0000_0900, 1'b1);
    i_branchwbInfo[1] = mk(6'h03, 64'h0000_0300, 1'b1);
    step();
    checks++; if (o_redirect_robIdx !== 6'h03) begin errors++; $display("FAIL oldest_rob got %h exp 03", o_redirect_robIdx); end
    checks++; if (o_redirect_pc !== 64'h300) begin errors++; $display("FAIL oldest_pc got %h exp 300", o_redirect_pc); end
    checks++; if (o_ftqupd_vld !== 2'b10) begin errors++; $display("FAIL oldest_ftqupd got %b exp 10", o_ftqupd_vld); end
    checks++; if (o_ftqupdInfo[1].rob_idx !== 6'h03) begin errors++; $display("FAIL oldest_info got %h exp 03", o_ftqupdInfo[1].rob_idx); end
    idle();
    i_redirect_rdy = 1'b1;
    step();
    checks++; if (o_mispred_cnt !== 32'd2) begin errors++; $display("FAIL oldest_cnt got %0d exp 2", o_mispred_cnt); end
    do_flush();
  endtask

  task automatic test_replace();
    idle();
    i_branchwb_vld    = 2'b01;
    i_branchwbInfo[0] = mk(6'h10, 64'h1000, 1'b1);
    step();
    checks++; if (o_redirect_robIdx !== 6'h10) begin errors++; $display("FAIL replace_first got %h exp 10", o_redirect_robIdx); end
    idle();
    i_branchwb_vld    = 2'b10;
    i_branchwbInfo[1] = mk(6'h0C, 64'h0C00, 1'b1);
    step();
    checks++; if (o_redirect_robIdx !== 6'h0C || o_redirect_pc !== 64'h0C00) begin errors++; $display("FAIL replace_older got rob %h pc %h exp rob 0c pc c00", o_redirect_robIdx, o_redirect_pc); end
    checks++; if (o_ftqupd_vld !== 2'b10) begin errors++; $display("FAIL replace_ftqupd got %b exp 10", o_ftqupd_vld); end
    idle();
    i_branchwb_vld    = 2'b01;
    i_branchwbInfo[0] = mk(6'h12, 64'h1200, 1'b1);
    step();
    checks++; if (o_redirect_robIdx !== 6'h0C || o_redirect_vld !== 1'b1) begin errors++; $display("FAIL replace_younger got rob %h vld %0b exp rob 0c vld 1", o_redirect_robIdx, o_redirect_vld); end
    checks++; if (o_ftqupd_vld !== 2'b00) begin errors++; $display("FAIL replace_kill got %b exp 00", o_ftqupd_vld); end
    idle();
    step();
    checks++; if (o_redirect_vld !== 1'b1 || o_redirect_pc !== 64'h0C00) begin errors++; $display("FAIL replace_hold got vld %0b pc %h exp vld 1 pc c00", o_redirect_vld, o_redirect_pc); end
    i_redirect_rdy = 1'b1;
    step();
    checks++; if (o_mispred_cnt !== 32'd3) begin errors++; $display("FAIL replace_cnt got %0d exp 3", o_mispred_cnt); end
    idle();
    i_branchwb_vld    = 2'b11;
    i_branchwbInfo[0] = mk(6'h0B, 64'h0B00, 1'b0);
    i_branchwbInfo[1] = mk(6'h14, 64'h1400, 1'b0);
    step();
    checks++; if (o_ftqupd_vld !== 2'b01) begin errors++; $display("FAIL replace_bnd_filter got %b exp 01", o_ftqupd_vld); end
    checks++; if (o_redirect_vld !== 1'b0) begin errors++; $display("FAIL replace_no_redirect got %0b exp 0", o_redirect_vld); end
    do_flush();
  endtask

  task automatic test_wrap();
    idle();
    i_branchwb_vld    = 2'b01;
    i_branchwbInfo[0] = mk(6'h1E, 64'h1E00, 1'b1);
    step();
    checks++; if (o_redirect_robIdx !== 6'h1E) begin errors++; $display("FAIL wrap_load got %h exp 1e", o_redirect_robIdx); end
    i_branchwbInfo[0] = mk(6'h21, 64'h2100, 1'b1);
    step();
    checks++; if (o_redirect_robIdx !== 6'h1E) begin errors++; $display("FAIL wrap_kill_rob got %h exp 1e", o_redirect_robIdx); end
    checks++; if (o_ftqupd_vld !== 2'b00) begin errors++; $display("FAIL wrap_kill_ftq got %b exp 00", o_ftqupd_vld); end
    i_branchwbInfo[0] = mk(6'h1D, 64'h1D00, 1'b1);
    step();
    checks++; if (o_redirect_robIdx !== 6'h1D) begin errors++; $display("FAIL wrap_older got %h exp 1d", o_redirect_robIdx); end
    checks++; if (o_ftqupd_vld !== 2'b01) begin errors++; $display("FAIL wrap_ftq got %b exp 01", o_ftqupd_vld); end
    idle();
    i_redirect_rdy = 1'b1;
    step();
    checks++; if (o_mispred_cnt !== 32'd4) begin errors++; $display("FAIL wrap_cnt got %0d exp 4", o_mispred_cnt); end
    do_flush();
  endtask

  task automatic test_flush();
    idle();
    i_branchwb_vld    = 2'b01;
    i_branchwbInfo[0] = mk(6'h08, 64'h0800, 1'b1);
    step();
    idle();
    i_flush           = 1'b1;
    i_branchwb_vld    = 2'b10;
    i_branchwbInfo[1] = mk(6'h02, 64'h0200, 1'b1);
    step();
    checks++; if (o_redirect_vld !== 1'b0) begin errors++; $display("FAIL flush_vld got %0b exp 0", o_redirect_vld); end
    checks++; if (o_ftqupd_vld !== 2'b00) begin errors++; $display("FAIL flush_ftq got %b exp 00", o_ftqupd_vld); end
    checks++; if (o_mispred_cnt !== 32'd4) begin errors++; $display("FAIL flush_cnt got %0d exp 4", o_mispred_cnt); end
    idle();
    i_branchwb_vld    = 2'b01;
    i_branchwbInfo[0] = mk(6'h30, 64'h3000, 1'b1);
    step();
    checks++; if (o_redirect_vld !== 1'b1 || o_redirect_robIdx !== 6'h30) begin errors++; $display("FAIL flush_after got vld %0b rob %h exp vld 1 rob 30", o_redirect_vld, o_redirect_robIdx); end
  endtask

  task automatic test_back_to_back();
    idle();
    i_redirect_rdy    = 1'b1;
    i_branchwb_vld    = 2'b01;
    i_branchwbInfo[0] = mk(6'h2F, 64'h2F00, 1'b1);
    step();
    checks++; if (o_redirect_vld !== 1'b1 || o_redirect_robIdx !== 6'h2F) begin errors++; $display("FAIL b2b_replace got vld %0b rob %h exp vld 1 rob 2f", o_redirect_vld, o_redirect_robIdx); end
    checks++; if (o_mispred_cnt !== 32'd5) begin errors++; $display("FAIL b2b_cnt1 got %0d exp 5", o_mispred_cnt); end
    idle();
    i_redirect_rdy = 1'b1;
    step();
    checks++; if (o_redirect_vld !== 1'b0 || o_mispred_cnt !== 32'd6) begin errors++; $display("FAIL b2b_cnt2 got vld %0b cnt %0d exp vld 0 cnt 6", o_redirect_vld, o_mispred_cnt); end
    do_flush();
  endtask

  task automatic test_reset_mid();
    idle();
    i_branchwb_vld    = 2'b01;
    i_branchwbInfo[0] = mk(6'h05, 64'h0500, 1'b1);
    step();
    idle();
    i_redirect_rdy = 1'b1;
    step();
    do_flush();
    i_branchwb_vld    = 2'b01;
    i_branchwbInfo[0] = mk(6'h06, 64'h0600, 1'b1);
    step();
    checks++; if (o_redirect_vld !== 1'b1 || o_mispred_cnt !== 32'd7) begin errors++; $display("FAIL rstmid_pre got vld %0b cnt %0d exp vld 1 cnt 7", o_redirect_vld, o_mispred_cnt); end
    rst = 1'b1;
    i_branchwbInfo[0] = mk(6'h04, 64'h0400, 1'b1);
    step();
    rst = 1'b0;
    idle();
    checks++; if (o_redirect_vld !== 1'b0 || o_ftqupd_vld !== 2'b00) begin errors++; $display("FAIL rstmid_vld got vld %0b ftq %b exp 0 00", o_redirect_vld, o_ftqupd_vld); end
    checks++; if (o_mispred_cnt !== 32'd0) begin errors++; $display("FAIL rstmid_cnt got %0d exp 0", o_mispred_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_single();
    test_oldest();
    test_replace();
    test_wrap();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Sits directly downstream of the ALU/BRU functional units, one instance per backend.
- Collects the per-cycle branch writebacks (`o_branchwb_vld` / `o_branchwbInfo`) from `NUM_BRU` units.
- Selects the oldest mispredicted branch and holds it as a single pending frontend redirect under a valid/ready handshake.
- Filters branch-resolution updates to the FTQ so that nothing younger than an issued redirect leaks through.

Parameters:
- `NUM_BRU`, 2, number of branch writeback ports (1..4).
- `ROB_W`, 6, robIdx width; MSB is the wrap flag, low `ROB_W-1` bits are the index.
- `CNT_W`, 32, width of the mispredict performance counter.

Ports:
- `clk`  in  1  core clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `i_branchwb_vld`  in  `NUM_BRU`  per-port branch writeback valid.
- `i_branchwbInfo`  in  `NUM_BRU` x `branchwbInfo_t`  per-port branch_type, rob_idx, ftq_idx, has_mispred, branch_taken, fallthruOffset, target_pc, branch_npc.
- `i_flush`  in  1  commit-stage full pipeline flush.
- `o_redirect_vld`  out  1  frontend redirect request pending.
- `i_redirect_rdy`  in  1  frontend accepts the redirect.
- `o_redirect_pc`  out  `XDEF`  redirect target (branch_npc).
- `o_redirect_ftqIdx`  out  `ftqIdx_t`  FTQ entry of the redirecting branch.
- `o_redirect_robIdx`  out  `ROB_W`  ROB index of the redirecting branch.
- `o_ftqupd_vld`  out  `NUM_BRU`  registered per-port FTQ update valid.
- `o_ftqupdInfo`  out  `NUM_BRU` x `branchwbInfo_t`  registered copy of the input info.
- `o_mispred_cnt`  out  `CNT_W`  count of redirects accepted by the frontend.

Behaviour:
- **Age compare.** Function `older(a,b)` is defined as:
  - flags differ: `a.idx > b.idx`;
  - flags equal: `a.idx < b.idx`;
  - equal rob_idx is never "older".
- **Candidate selection** (combinational, same cycle as input):
  - Consider ports with `vld && has_mispred`.
  - Pick the oldest; on an equal rob_idx take the lowest port and assert, since this is illegal.
- **Boundary register.** `bnd_vld`/`bnd_rob` holds the rob_idx of the last loaded redirect.
  - A candidate or FTQ update is "killed" when `bnd_vld` is set and it is not older than `bnd_rob`.
- **Pending register** (`o_redirect_*`), evaluated each cycle in priority order:
  1. `rst`: `o_redirect_vld`=0, `bnd_vld`=0, `o_ftqupd_vld`=0, `o_mispred_cnt`=0; data regs don't-care.
  2. `i_flush`: `o_redirect_vld`=0 and `bnd_vld`=0; same-cycle candidates and updates are dropped. A flush during a pending, un-accepted redirect discards it without incrementing the counter.
  3. A live (unkilled) candidate exists: load it into pending, set `o_redirect_vld`=1, `bnd_rob`=cand.rob_idx, `bnd_vld`=1.
     - This replaces any un-accepted pending redirect, because the candidate is necessarily older.
     - If the old pending entry was accepted this same cycle, the counter still increments for it.
  4. Otherwise, if `o_redirect_vld && i_redirect_rdy`: `o_redirect_vld`=0 and the counter increments by 1 (wraps at 2^`CNT_W`).
     - `bnd_vld` stays set until `i_flush`; younger wrong-path branches remain filtered.
- **Latency.** Branch writeback to `o_redirect_vld` is 1 cycle.
  - `o_redirect_*` is stable while `vld && !rdy`, unless an older candidate replaces it (rule 3).
- **FTQ update path.** Registered 1 cycle, no backpressure.
  - `o_ftqupd_vld[i] <= i_branchwb_vld[i] && !killed(i) && !i_flush`.
  - The info is copied unconditionally.
  - A port carrying the redirecting branch itself is not killed; killing uses `bnd` before the update.
  - Same-cycle younger ports are killed by the same-cycle candidate: a port is killed if the candidate is older than it.
- **Wrap-around.** Flag-based compare must hold across the index wrap, e.g. rob 0x20 (flag=1, idx 0) is younger than 0x1F.
- **Assertion.** No `i_branchwb_vld` with `has_mispred` where `branch_type==isDirect`.

Test Plan:
- **Single mispredict:** port0 vld, rob=0x05, mispred, npc=0x8000_1000, rdy=1 next cycle → cycle+1 `o_redirect_vld`=1 with pc 0x8000_1000, cycle+2 vld=0 and `o_mispred_cnt`=1.
- **Oldest select:** port0 rob=0x09 and port1 rob=0x03, both mispredicting in the same cycle → redirect rob=0x03; `o_ftqupd_vld`=2'b10 (port0 killed).
- **Older replaces pending:** pending rob=0x10 held with rdy=0, then port1 mispredicts rob=0x0C → redirect switches to 0x0C; then a younger rob=0x12 arrives → ignored, and its FTQ update is killed.
- **Wrap:** `bnd_rob`=0x1E, then port0 mispredicts rob=0x21 (flag=1, idx 1) → killed; rob=0x1D → accepted as the new redirect.
- **Flush:** pending redirect with rdy=0, then `i_flush`=1 together with a new mispredict → next cycle vld=0, counter unchanged; after the flush, rob=0x30 is accepted.
- **Reset mid-op:** `rst` asserted with pending vld=1 and counter=7 → next cycle all valids 0 and counter 0.
